// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB4 bridge.
// State encodings are plain 2-bit constants so older RTL can compare them against raw state vectors.
package apb_bridge_pkg;

    localparam int APB_DATAWIDTH = 32;
    localparam int APB_ADDRWIDTH = 32;

    localparam logic [2:0] PROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PROT_INSTRUCTION = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    typedef struct packed {
        logic                       write;
        logic [APB_ADDRWIDTH-1:0]   addr;
        logic [APB_DATAWIDTH-1:0]   wdata;
        logic [APB_DATAWIDTH/8-1:0] strb;
        logic [2:0]                 prot;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATAWIDTH-1:0] rdata;
        logic                     slverr;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: clears on entry, counts enabled cycles, and flags the enabled
// cycle on which the count reaches LIMIT.
module apb_timeout_cnt #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] countReg;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (enable) begin
            countReg <= countReg + CNT_W'(1);
        end
    end

    // Combinational so the abort is taken on the very cycle the limit is reached.
    assign expired = enable && (countReg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_fsm.sv
// APB4 requester FSM: one request in, SETUP/ACCESS on APB, one response out; all outputs registered.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES cycles without pready.
module apb_master_fsm
    import apb_bridge_pkg::*;
#(
    parameter int DATAWIDTH      = APB_DATAWIDTH,
    parameter int ADDRWIDTH      = APB_ADDRWIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDRWIDTH-1:0]   req_addr,
    input  logic [DATAWIDTH-1:0]   req_wdata,
    input  logic [DATAWIDTH/8-1:0] req_strb,
    input  logic [2:0]             req_prot,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATAWIDTH-1:0]   rsp_rdata,
    output logic                   rsp_slverr,
    output logic                   pselx,
    output logic                   penable,
    output logic                   pwrite,
    output logic [ADDRWIDTH-1:0]   paddr,
    output logic [DATAWIDTH-1:0]   pwdata,
    output logic [DATAWIDTH/8-1:0] pstrb,
    output logic [2:0]             pprot,
    input  logic                   pready,
    input  logic                   pslverr,
    input  logic [DATAWIDTH-1:0]   prdata
);

    localparam int STRB_W = DATAWIDTH / 8;

    logic [1:0]           stateReg;
    logic [STRB_W-1:0]    strbMasked;
    logic [DATAWIDTH-1:0] wdataMasked;
    logic                 timeoutExpired;

    // Reads carry no strobes and no write data on the bus.
    genvar gi;
    for (gi = 0; gi < STRB_W; gi++) begin : gLane
        assign strbMasked[gi]          = req_write & req_strb[gi];
        assign wdataMasked[gi*8 +: 8]  = req_write ? req_wdata[gi*8 +: 8] : 8'h00;
    end

`ifdef APB_TIMEOUT_EN
    logic enterAccess;
    logic accessWait;

    assign enterAccess = (stateReg == ST_SETUP);
    assign accessWait  = (stateReg == ST_ACCESS) && !pready;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) uTimeout (
        .clk     (pclk),
        .rstN    (presetn),
        .clear   (enterAccess),
        .enable  (accessWait),
        .expired (timeoutExpired)
    );
`else
    assign timeoutExpired = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            stateReg   <= ST_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            pselx      <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            pprot      <= '0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        pselx     <= 1'b1;
                        penable   <= 1'b0;
                        pwrite    <= req_write;
                        paddr     <= req_addr;
                        pwdata    <= wdataMasked;
                        pstrb     <= strbMasked;
                        pprot     <= req_prot;
                        stateReg  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable  <= 1'b1;
                    stateReg <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority over a timeout expiring in the same cycle.
                    if (pready || timeoutExpired) begin
                        pselx      <= 1'b0;
                        penable    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_slverr <= pready ? pslverr : 1'b1;
                        rsp_rdata  <= (pready && !pwrite) ? prdata : '0;
                        stateReg   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_rdata  <= '0;
                        rsp_slverr <= 1'b0;
                        req_ready  <= 1'b1;
                        stateReg   <= ST_IDLE;
                    end
                end
                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: a table of transfers checked through a response scoreboard,
// plus hand sequences for reset, back-pressure and the ACCESS timeout (APB_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_apb_master_fsm;
    import apb_bridge_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_strb = '0;
    logic [2:0]    req_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [DW-1:0] prdata = '0;

    apb_master_fsm #(
        .DATAWIDTH      (DW),
        .ADDRWIDTH      (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .req_prot   (req_prot),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pprot      (pprot),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        apb_req_t      req;
        logic [DW-1:0] prdata;
        logic          pslverr;
        int            waits;
        int            rspDelay;
        apb_rsp_t      rsp;
    } vec_t;

    apb_rsp_t expQ[$];
    int total = 0;
    int bad = 0;
    int rspCount = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Scoreboard: the response is sampled at the negedge before the handshake edge.
    always @(negedge pclk) begin
        if (presetn && rsp_valid && rsp_ready) begin
            apb_rsp_t e;
            rspCount++;
            $display("rsp %0d: rdata=%h slverr=%0d", rspCount, rsp_rdata, rsp_slverr);
            if (expQ.size() == 0) begin
                chk("unexpected_rsp", 64'(expQ.size()), 64'd1);
            end else begin
                e = expQ.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_slverr", 64'(rsp_slverr), 64'(e.slverr));
            end
        end
    end

    task automatic xfer(input vec_t v);
        int cyc;
        bit done;
        $display("xfer: write=%0d addr=%h wdata=%h strb=%h waits=%0d rspDelay=%0d",
                 v.req.write, v.req.addr, v.req.wdata, v.req.strb, v.waits, v.rspDelay);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = v.req.write;
        req_addr  = v.req.addr;
        req_wdata = v.req.wdata;
        req_strb  = v.req.strb;
        req_prot  = v.req.prot;
        expQ.push_back(v.rsp);
        tick();
        req_valid = 1'b0;
        chk("setup_ctrl", {61'd0, pselx, penable, req_ready}, 64'b100);
        chk("setup_pwrite", 64'(pwrite), 64'(v.req.write));
        chk("setup_paddr", 64'(paddr), 64'(v.req.addr));
        chk("setup_pwdata", 64'(pwdata), v.req.write ? 64'(v.req.wdata) : 64'd0);
        chk("setup_pstrb", 64'(pstrb), v.req.write ? 64'(v.req.strb) : 64'd0);
        chk("setup_pprot", 64'(pprot), 64'(v.req.prot));
        tick();
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 50) begin
            chk("access_ctrl", {62'd0, pselx, penable}, 64'b11);
            chk("access_paddr", 64'(paddr), 64'(v.req.addr));
            // Junk on prdata/pslverr during wait states must be ignored.
            pready  = (cyc == v.waits);
            pslverr = pready ? v.pslverr : 1'b1;
            prdata  = pready ? v.prdata : DW'($urandom);
            done    = pready;
            tick();
            cyc++;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        chk("access_cycles", 64'(cyc), 64'(v.waits + 1));
        chk("resp_ctrl", {61'd0, pselx, penable, rsp_valid}, 64'b001);
        for (int i = 0; i < v.rspDelay; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'hBAD0_0000;
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(v.rsp.rdata));
            chk("hold_req_psel", {62'd0, req_ready, pselx}, 64'd0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_rsp", {62'd0, rsp_valid, req_ready}, 64'b01);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t longWait;
        int cyc;

        vecs[0] = '{req: '{write: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF, strb: 4'hF, prot: 3'b000},
                    prdata: 32'h0, pslverr: 1'b0, waits: 0, rspDelay: 0,
                    rsp: '{rdata: 32'h0, slverr: 1'b0}};
        vecs[1] = '{req: '{write: 1'b0, addr: 32'h20, wdata: 32'h0, strb: 4'hF, prot: 3'b000},
                    prdata: 32'h12345678, pslverr: 1'b0, waits: 3, rspDelay: 0,
                    rsp: '{rdata: 32'h12345678, slverr: 1'b0}};
        vecs[2] = '{req: '{write: 1'b1, addr: 32'h30, wdata: 32'hCAFEF00D, strb: 4'h3, prot: PROT_NONSECURE},
                    prdata: 32'h0, pslverr: 1'b1, waits: 1, rspDelay: 2,
                    rsp: '{rdata: 32'h0, slverr: 1'b1}};
        vecs[3] = '{req: '{write: 1'b0, addr: 32'h44, wdata: 32'h11111111, strb: 4'hC, prot: 3'b101},
                    prdata: 32'hA5A55A5A, pslverr: 1'b1, waits: 0, rspDelay: 5,
                    rsp: '{rdata: 32'hA5A55A5A, slverr: 1'b1}};
        vecs[4] = '{req: '{write: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h0F0F0F0F, strb: 4'h9, prot: PROT_PRIVILEGED},
                    prdata: 32'hFFFFFFFF, pslverr: 1'b0, waits: 2, rspDelay: 1,
                    rsp: '{rdata: 32'h0, slverr: 1'b0}};
        longWait = '{req: '{write: 1'b0, addr: 32'h70, wdata: 32'h0, strb: 4'h0, prot: 3'b000},
                     prdata: 32'h0BADF00D, pslverr: 1'b0, waits: 20, rspDelay: 0,
                     rsp: '{rdata: 32'h0BADF00D, slverr: 1'b0}};

        // Reset state
        tick();
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_outputs", {54'd0, rsp_valid, pselx, penable, pwrite, |paddr, |pwdata,
                              |pstrb, |pprot, |rsp_rdata, rsp_slverr}, 64'd0);
        presetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            xfer(vecs[i]);
        end

        // Reset in the middle of ACCESS: outputs drop at once, pending transfer is lost.
        $display("xfer: read addr=00000060 interrupted by reset");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h60;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_reset_access", {62'd0, pselx, penable}, 64'b11);
        #2;
        presetn = 1'b0;
        #1;
        chk("midreset_req_ready", 64'(req_ready), 64'd1);
        chk("midreset_outputs", {54'd0, rsp_valid, pselx, penable, pwrite, |paddr, |pwdata,
                                 |pstrb, |pprot, |rsp_rdata, rsp_slverr}, 64'd0);
        tick();
        tick();
        presetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_idle", {61'd0, req_ready, rsp_valid, pselx}, 64'b100);
        end

        xfer(vecs[0]);

`ifdef APB_TIMEOUT_EN
        $display("xfer: read addr=00000050 with pready never asserted");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h50;
        tick();
        req_valid = 1'b0;
        tick();
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hFFFFFFFF;
        cyc = 0;
        while (penable === 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        pslverr = 1'b0;
        prdata  = '0;
        chk("timeout_access_cycles", 64'(cyc), 64'(TO));
        chk("timeout_resp", {61'd0, pselx, rsp_valid, rsp_slverr}, 64'b011);
        chk("timeout_rdata", 64'(rsp_rdata), 64'd0);
        expQ.push_back('{rdata: 32'h0, slverr: 1'b1});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("timeout_post_rsp", {62'd0, rsp_valid, req_ready}, 64'b01);
`else
        xfer(longWait);
`endif

        tick();
        chk("scoreboard_drained", 64'(expQ.size()), 64'd0);
        chk("rsp_count", 64'(rspCount), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
